// File: rtl/rx_mode_pkg.sv
// ---------------------------------------------------------------------------
// rx_mode_pkg
// Shared types for the receive-path redundancy mode controller:
//   - state_t      : controller FSM states
//   - MODE_*       : encodings of the applied/requested mode
//   - mode_to_red  : maps a mode encoding to its voter redundancy (1/3/5/0)
// ---------------------------------------------------------------------------
package rx_mode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FRAME = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SKIP  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_1X  = 2'd0;
  localparam logic [1:0] MODE_3X  = 2'd1;
  localparam logic [1:0] MODE_5X  = 2'd2;
  localparam logic [1:0] MODE_OFF = 2'd3;

  function automatic logic [2:0] mode_to_red(input logic [1:0] mode);
    case (mode)
      MODE_1X: return 3'd1;
      MODE_3X: return 3'd3;
      MODE_5X: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rx_sw_debounce.sv
// ---------------------------------------------------------------------------
// rx_sw_debounce
// Two-flop synchronizer followed by a stability filter. A new value is
// accepted on o_stable only after the synchronized input has held it for
// DEBOUNCE_CYC consecutive clocks; any change restarts the count.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (clears to all-zeros)
//   i_raw     in   W  raw asynchronous input
//   o_stable  out  W  debounced, accepted value
// ---------------------------------------------------------------------------
module rx_sw_debounce
  import rx_mode_pkg::*;
#(
  parameter int W            = 2,
  parameter int DEBOUNCE_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_stable
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYC);

  logic [W-1:0]  r_sync1;
  logic [W-1:0]  r_sync2;
  logic [W-1:0]  r_cand;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_stable;

  // r_cnt holds the number of consecutive cycles r_sync2 has equalled r_cand.
  // It parks at CNT_FULL so an already-accepted value is not re-counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_cnt    <= CNT_FULL;
      r_stable <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= CNT_ONE;
        if (DEBOUNCE_CYC == 1) r_stable <= r_sync2;
      end else if (r_cnt != CNT_FULL) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CNT_FULL - CW'(1)) r_stable <= r_cand;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/rx_mode_ctrl.sv
// ---------------------------------------------------------------------------
// rx_mode_ctrl
// Applies the switch-selected voter redundancy mode to the receive path,
// only between frames. A mode change drains the voters (path_rst_n low for
// DRAIN_CYC cycles); a frame that starts while draining is discarded.
// Optional frame/loss statistics counters are built only when the macro
// RX_MODE_STATS_EN is defined; otherwise the counter outputs are tied to 0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mode_req     2  raw switch value (asynchronous)
//   rx_enable    1  PHY frame-valid
//   en_in        1  en_out of the selected voter path (qualified externally)
//   loss_in      1  loss flag of the selected voter path
//   clr_cnt      1  synchronous clear of the statistics counters
//   mode_sel     2  applied mode (0=1x, 1=3x, 2=5x, 3=disabled)
//   redundancy   3  applied redundancy (1/3/5, 0 when disabled)
//   path_rst_n   1  active-low reset to the voter instances
//   en_gate      1  qualifier for en_in toward downstream logic
//   busy         1  switch pending or draining
//   frame_cnt    CNT_W  frames accepted (saturating)
//   loss_cnt     CNT_W  loss events (saturating)
// ---------------------------------------------------------------------------
module rx_mode_ctrl
  import rx_mode_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1024,
  parameter int GAP_CYC      = 12,
  parameter int DRAIN_CYC    = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode_req,
  input  logic             rx_enable,
  input  logic             en_in,
  input  logic             loss_in,
  input  logic             clr_cnt,
  output logic [1:0]       mode_sel,
  output logic [2:0]       redundancy,
  output logic             path_rst_n,
  output logic             en_gate,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYC);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_mode;
  logic [1:0]         w_mode_nxt;
  logic [1:0]         w_acc;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic               r_path_rst_n;
  logic               r_en_gate;
  logic               w_en_nxt;
  logic               w_frame_start;

  rx_sw_debounce #(
    .W            (2),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raw    (mode_req),
    .o_stable (w_acc)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_gap_nxt     = r_gap_cnt;
    w_drain_nxt   = r_drain_cnt;
    w_frame_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_enable) begin
          w_state_nxt   = ST_FRAME;
          w_frame_start = 1'b1;
        end else if (w_acc != r_mode) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = '0;
        end
      end
      ST_FRAME: begin
        if (!rx_enable) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = GAP_ONE;
        end
      end
      ST_GAP: begin
        // A short gap rejoins the same frame; only a full gap returns to IDLE.
        if (rx_enable) begin
          w_state_nxt = ST_FRAME;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      ST_DRAIN: begin
        // The mode is sampled at drain end, so a re-request during DRAIN
        // takes effect without restarting the drain.
        if (r_drain_cnt == DRAIN_LAST) begin
          w_mode_nxt  = w_acc;
          w_state_nxt = rx_enable ? ST_SKIP : ST_IDLE;
        end else begin
          w_drain_nxt = r_drain_cnt + DRAIN_W'(1);
        end
      end
      ST_SKIP: begin
        if (!rx_enable) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = GAP_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Gate outputs are registered from the next state so the voter reset
  // and enable qualifier are glitch-free.
  assign w_en_nxt = ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FRAME) ||
                     (w_state_nxt == ST_GAP)) && (w_mode_nxt != MODE_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_1X;
      r_gap_cnt    <= '0;
      r_drain_cnt  <= '0;
      r_path_rst_n <= 1'b0;
      r_en_gate    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_drain_cnt  <= w_drain_nxt;
      r_path_rst_n <= (w_state_nxt != ST_DRAIN);
      r_en_gate    <= w_en_nxt;
    end
  end

  assign mode_sel   = r_mode;
  assign redundancy = mode_to_red(r_mode);
  assign path_rst_n = r_path_rst_n;
  assign en_gate    = r_en_gate;
  assign busy       = (w_acc != r_mode) || (r_state == ST_DRAIN);

`ifdef RX_MODE_STATS_EN
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_loss_cnt;
  logic             r_loss_d;
  logic             w_frame_inc;
  logic             w_loss_inc;
  logic             w_unused;

  // Frames are still counted with the path disabled; losses are not.
  assign w_frame_inc = w_frame_start && (r_en_gate || (r_mode == MODE_OFF));
  assign w_loss_inc  = loss_in && !r_loss_d && r_en_gate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_loss_cnt  <= '0;
      r_loss_d    <= 1'b0;
    end else begin
      r_loss_d <= loss_in;
      if (clr_cnt) begin
        r_frame_cnt <= '0;
        r_loss_cnt  <= '0;
      end else begin
        if (w_frame_inc && !(&r_frame_cnt)) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        if (w_loss_inc && !(&r_loss_cnt))   r_loss_cnt  <= r_loss_cnt + CNT_W'(1);
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign loss_cnt  = r_loss_cnt;
  assign w_unused  = en_in;
`else
  logic w_unused;

  assign frame_cnt = '0;
  assign loss_cnt  = '0;
  assign w_unused  = ^{en_in, loss_in, clr_cnt, w_frame_start};
`endif

endmodule

// File: tb/tb_rx_mode_ctrl.sv
module tb_rx_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_req;
  logic       rx_enable;
  logic       en_in;
  logic       loss_in;
  logic       clr_cnt;
  logic [1:0] mode_sel;
  logic [2:0] redundancy;
  logic       path_rst_n;
  logic       en_gate;
  logic       busy;
  logic [3:0] frame_cnt;
  logic [3:0] loss_cnt;

  int total = 0;
  int bad   = 0;

`ifdef RX_MODE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  rx_mode_ctrl #(
    .DEBOUNCE_CYC (4),
    .GAP_CYC      (12),
    .DRAIN_CYC    (8),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_req   (mode_req),
    .rx_enable  (rx_enable),
    .en_in      (en_in),
    .loss_in    (loss_in),
    .clr_cnt    (clr_cnt),
    .mode_sel   (mode_sel),
    .redundancy (redundancy),
    .path_rst_n (path_rst_n),
    .en_gate    (en_gate),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  // Reference: a count of events, saturating at 4 bits; 0 when stats are absent.
  function automatic logic [3:0] exp_cnt(input int n);
    if (!STATS) return 4'd0;
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_prst(input logic val, input int limit, output int waited);
    waited = 0;
    while (path_rst_n !== val && waited < limit) begin
      tick();
      waited++;
    end
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  task automatic run_frame(input int len, input int gap, input int loss_at);
    for (int i = 0; i < len; i++) begin
      rx_enable = 1'b1;
      loss_in   = (i == loss_at);
      tick();
    end
    loss_in   = 1'b0;
    rx_enable = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode_req = 2'd0; rx_enable = 1'b0; en_in = 1'b0;
    loss_in = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    total++; if (mode_sel !== 2'd0) begin bad++; $display("FAIL reset_mode_sel: got %0d want 0", mode_sel); end
    total++; if (redundancy !== 3'd1) begin bad++; $display("FAIL reset_redundancy: got %0d want 1", redundancy); end
    total++; if (path_rst_n !== 1'b0) begin bad++; $display("FAIL reset_path_rst_n: got %0d want 0", path_rst_n); end
    total++; if (en_gate !== 1'b0) begin bad++; $display("FAIL reset_en_gate: got %0d want 0", en_gate); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0d want 0", busy); end
    total++; if (frame_cnt !== 4'd0 || loss_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_counters: got frame=%0d loss=%0d want 0/0", frame_cnt, loss_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    total++; if (path_rst_n !== 1'b1) begin bad++; $display("FAIL release_path_rst_n: got %0d want 1", path_rst_n); end
    total++; if (en_gate !== 1'b1) begin bad++; $display("FAIL release_en_gate: got %0d want 1", en_gate); end
    repeat (5) tick();
  endtask

  task automatic test_switch_idle();
    int w;
    mode_req = 2'd1;
    wait_prst(1'b0, 40, w);
    total++; if (path_rst_n !== 1'b0 || w < 6 || w > 9) begin
      bad++; $display("FAIL switch_latency: got %0d cycles (prst=%0d) want 6..9", w, path_rst_n);
    end
    total++; if (en_gate !== 1'b0) begin bad++; $display("FAIL switch_drain_gate: got %0d want 0", en_gate); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL switch_busy: got %0d want 1", busy); end
    wait_prst(1'b1, 30, w);
    total++; if (w !== 8) begin bad++; $display("FAIL switch_drain_len: got %0d want 8", w); end
    total++; if (mode_sel !== 2'd1 || redundancy !== 3'd3) begin
      bad++; $display("FAIL switch_applied: got mode=%0d red=%0d want 1/3", mode_sel, redundancy);
    end
    total++; if (busy !== 1'b0 || en_gate !== 1'b1) begin
      bad++; $display("FAIL switch_done: got busy=%0d gate=%0d want 0/1", busy, en_gate);
    end
    repeat (4) tick();
  endtask

  task automatic test_defer();
    int w;
    int viol;
    pulse_clr();
    viol = 0;
    rx_enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) mode_req = 2'd2;
      tick();
      if (path_rst_n !== 1'b1 || mode_sel !== 2'd1) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL defer_in_frame: got %0d bad cycles want 0", viol); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL defer_busy: got %0d want 1", busy); end
    rx_enable = 1'b0;
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (path_rst_n !== 1'b1 || mode_sel !== 2'd1) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL defer_in_gap: got %0d bad cycles want 0", viol); end
    wait_prst(1'b0, 10, w);
    total++; if (path_rst_n !== 1'b0) begin bad++; $display("FAIL defer_drain_start: got prst=%0d after %0d want 0", path_rst_n, w); end
    wait_prst(1'b1, 20, w);
    total++; if (w !== 8) begin bad++; $display("FAIL defer_drain_len: got %0d want 8", w); end
    total++; if (mode_sel !== 2'd2 || redundancy !== 3'd5) begin
      bad++; $display("FAIL defer_applied: got mode=%0d red=%0d want 2/5", mode_sel, redundancy);
    end
    total++; if (frame_cnt !== exp_cnt(1)) begin bad++; $display("FAIL defer_frames: got %0d want %0d", frame_cnt, exp_cnt(1)); end
    repeat (4) tick();
  endtask

  task automatic test_skip();
    int w;
    int viol;
    pulse_clr();
    mode_req = 2'd0;
    wait_prst(1'b0, 40, w);
    total++; if (path_rst_n !== 1'b0) begin bad++; $display("FAIL skip_drain_start: got %0d want 0", path_rst_n); end
    tick();
    tick();
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      rx_enable = 1'b1;
      loss_in   = (i == 12);
      tick();
      if (en_gate !== 1'b0) viol++;
    end
    loss_in = 1'b0;
    total++; if (viol !== 0) begin bad++; $display("FAIL skip_gate: got %0d open cycles want 0", viol); end
    rx_enable = 1'b0;
    repeat (20) tick();
    total++; if (mode_sel !== 2'd0 || en_gate !== 1'b1) begin
      bad++; $display("FAIL skip_after: got mode=%0d gate=%0d want 0/1", mode_sel, en_gate);
    end
    total++; if (frame_cnt !== exp_cnt(0) || loss_cnt !== exp_cnt(0)) begin
      bad++; $display("FAIL skip_counts: got frame=%0d loss=%0d want 0/0", frame_cnt, loss_cnt);
    end
  endtask

  task automatic test_glitch();
    int viol;
    viol = 0;
    mode_req = 2'd1;
    tick(); if (busy !== 1'b0) viol++;
    tick(); if (busy !== 1'b0) viol++;
    mode_req = 2'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b0 || path_rst_n !== 1'b1 || mode_sel !== 2'd0) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL glitch_ignored: got %0d bad cycles want 0", viol); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %0d want 0", busy); end
  endtask

  task automatic test_counters();
    pulse_clr();
    run_frame(10, 16, 3);
    run_frame(10, 16, -1);
    run_frame(10, 16, 5);
    total++; if (frame_cnt !== exp_cnt(3) || loss_cnt !== exp_cnt(2)) begin
      bad++; $display("FAIL cnt_three: got frame=%0d loss=%0d want %0d/%0d", frame_cnt, loss_cnt, exp_cnt(3), exp_cnt(2));
    end
    rx_enable = 1'b1;
    clr_cnt   = 1'b1;
    tick();
    clr_cnt = 1'b0;
    total++; if (frame_cnt !== 4'd0 || loss_cnt !== 4'd0) begin
      bad++; $display("FAIL cnt_clr_priority: got frame=%0d loss=%0d want 0/0", frame_cnt, loss_cnt);
    end
    run_frame(9, 16, -1);
    total++; if (frame_cnt !== 4'd0) begin bad++; $display("FAIL cnt_after_clr: got %0d want 0", frame_cnt); end
    pulse_clr();
    for (int i = 0; i < 20; i++) run_frame(5, 16, 2);
    total++; if (frame_cnt !== exp_cnt(20) || loss_cnt !== exp_cnt(20)) begin
      bad++; $display("FAIL cnt_saturate: got frame=%0d loss=%0d want %0d/%0d", frame_cnt, loss_cnt, exp_cnt(20), exp_cnt(20));
    end
  endtask

  task automatic test_random();
    int nb, nseg, len, la, mf, ml;
    pulse_clr();
    mf = 0;
    ml = 0;
    nb = int'($urandom_range(6, 10));
    for (int b = 0; b < nb; b++) begin
      nseg = int'($urandom_range(1, 3));
      for (int s = 0; s < nseg; s++) begin
        len = int'($urandom_range(3, 15));
        la  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
        if (la >= 0) ml++;
        for (int i = 0; i < len; i++) begin
          rx_enable = 1'b1;
          loss_in   = (i == la);
          en_in     = 1'($urandom_range(0, 1));
          tick();
        end
        loss_in   = 1'b0;
        rx_enable = 1'b0;
        if (s < nseg - 1) repeat (int'($urandom_range(2, 8))) tick();
      end
      repeat (int'($urandom_range(16, 25))) tick();
      mf++;
      total++; if (frame_cnt !== exp_cnt(mf) || loss_cnt !== exp_cnt(ml)) begin
        bad++; $display("FAIL rand_burst%0d: got frame=%0d loss=%0d want %0d/%0d", b, frame_cnt, loss_cnt, exp_cnt(mf), exp_cnt(ml));
      end
    end
    en_in = 1'b0;
  endtask

  task automatic test_mode_off();
    int w;
    mode_req = 2'd3;
    wait_prst(1'b0, 40, w);
    total++; if (path_rst_n !== 1'b0) begin bad++; $display("FAIL off_drain_start: got %0d want 0", path_rst_n); end
    wait_prst(1'b1, 20, w);
    tick();
    total++; if (mode_sel !== 2'd3 || redundancy !== 3'd0 || en_gate !== 1'b0) begin
      bad++; $display("FAIL off_applied: got mode=%0d red=%0d gate=%0d want 3/0/0", mode_sel, redundancy, en_gate);
    end
    pulse_clr();
    run_frame(8, 16, 2);
    run_frame(8, 16, 4);
    total++; if (frame_cnt !== exp_cnt(2) || loss_cnt !== exp_cnt(0)) begin
      bad++; $display("FAIL off_counts: got frame=%0d loss=%0d want %0d/%0d", frame_cnt, loss_cnt, exp_cnt(2), exp_cnt(0));
    end
    total++; if (en_gate !== 1'b0) begin bad++; $display("FAIL off_gate: got %0d want 0", en_gate); end
  endtask

  task automatic test_reset_mid_drain();
    int w;
    int viol;
    mode_req = 2'd1;
    wait_prst(1'b0, 40, w);
    total++; if (path_rst_n !== 1'b0 || mode_sel !== 2'd3) begin
      bad++; $display("FAIL rstd_drain: got prst=%0d mode=%0d want 0/3", path_rst_n, mode_sel);
    end
    tick();
    tick();
    rst_n    = 1'b0;
    mode_req = 2'd0;
    #2;
    total++; if (mode_sel !== 2'd0 || redundancy !== 3'd1) begin
      bad++; $display("FAIL rstd_mode: got mode=%0d red=%0d want 0/1", mode_sel, redundancy);
    end
    total++; if (path_rst_n !== 1'b0 || en_gate !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstd_ctrl: got prst=%0d gate=%0d busy=%0d want 0/0/0", path_rst_n, en_gate, busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (path_rst_n !== 1'b1 || en_gate !== 1'b1) begin
      bad++; $display("FAIL rstd_release: got prst=%0d gate=%0d want 1/1", path_rst_n, en_gate);
    end
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (path_rst_n !== 1'b1 || busy !== 1'b0 || mode_sel !== 2'd0) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL rstd_no_switch: got %0d bad cycles want 0", viol); end
    total++; if (frame_cnt !== 4'd0 || loss_cnt !== 4'd0) begin
      bad++; $display("FAIL rstd_counters: got frame=%0d loss=%0d want 0/0", frame_cnt, loss_cnt);
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_switch_idle();
    test_defer();
    test_skip();
    test_glitch();
    test_counters();
    test_random();
    test_mode_off();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_mode_ctrl.md
RX_MODE_CTRL -- requirements
Module: rx_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 1024, meaning consecutive cycles mode_req must be stable before acceptance.
REQ-002 SHALL have parameter GAP_CYC, default 12, meaning minimum rx_enable-low cycles that define an inter-frame gap.
REQ-003 SHALL have parameter DRAIN_CYC, default 8, meaning cycles path_rst_n is held low during a mode switch.
REQ-004 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  rx clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- mode_req  in  2  raw switch value (switches[5:4]), asynchronous to clk.
- rx_enable  in  1  PHY frame-valid.
- en_in  in  1  en_out of the currently selected voter path.
- loss_in  in  1  loss flag of the currently selected voter path.
- clr_cnt  in  1  synchronous clear of the statistics counters.
- mode_sel  out  2  applied mode: 0=1x, 1=3x, 2=5x, 3=disabled.
- redundancy  out  3  applied redundancy: 1, 3, 5; 0 when disabled.
- path_rst_n  out  1  active-low reset to the voter instances.
- en_gate  out  1  qualifies en_in toward downstream logic.
- busy  out  1  high while a switch is pending or draining.
- frame_cnt  out  CNT_W  frames accepted.
- loss_cnt  out  CNT_W  loss events.

Function
REQ-006 SHALL pass mode_req through a 2-flop synchronizer, then accept a value only after it has been stable for DEBOUNCE_CYC consecutive cycles; any change restarts the count.
REQ-007 SHALL implement the states IDLE, FRAME, GAP, DRAIN and SKIP.
REQ-008 IDLE: rx_enable=1 -> FRAME; else, if the accepted mode differs from the applied mode -> DRAIN.
REQ-009 FRAME: rx_enable=0 -> GAP, with the gap counter loaded to 1.
REQ-010 GAP: rx_enable=1 before GAP_CYC -> FRAME (a short gap is treated as the same frame); when the count reaches GAP_CYC -> IDLE.
REQ-011 DRAIN: path_rst_n=0 and en_gate=0 for exactly DRAIN_CYC cycles; on the last cycle mode_sel/redundancy update to the accepted mode; next state is SKIP if rx_enable=1, else IDLE.
REQ-012 SKIP: en_gate=0 until rx_enable=0, then GAP; a frame that starts during DRAIN is discarded in full and not counted.
REQ-013 en_gate SHALL be 1 in IDLE, FRAME and GAP, and 0 in DRAIN and SKIP; it SHALL also be 0 whenever mode_sel=3.
REQ-014 A mode change accepted during FRAME or GAP SHALL be deferred until IDLE; it never takes effect mid-frame.
REQ-015 If the accepted mode changes again during DRAIN, the new value SHALL be applied at DRAIN end; DRAIN is not restarted.
REQ-016 busy SHALL be 1 when the accepted mode differs from the applied mode, or in DRAIN.
REQ-017 frame_cnt SHALL increment on each IDLE->FRAME transition while en_gate=1.
REQ-018 loss_cnt SHALL increment on each rising edge of loss_in while en_gate=1.
REQ-019 Both counters SHALL saturate at all-ones.
REQ-020 clr_cnt SHALL zero both counters next cycle and takes priority over a simultaneous increment.
REQ-021 mode_sel=3 SHALL still count frames; loss_cnt is not incremented in that mode.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE, mode_sel=0, redundancy=1, path_rst_n=0, en_gate=0, busy=0, counters=0, synchronizer/debounce cleared with accepted mode=0.
REQ-023 After rst_n deasserts, path_rst_n and en_gate SHALL go to 1 on the first clk edge.
REQ-024 Reset mid-DRAIN or mid-frame SHALL abandon the operation with no pending switch retained.

Configuration
REQ-025 With RX_MODE_STATS_EN defined, frame_cnt, loss_cnt and clr_cnt SHALL be implemented as specified.
REQ-026 Without RX_MODE_STATS_EN, frame_cnt and loss_cnt SHALL be tied to 0, clr_cnt is ignored, and no counter flops exist.

Structure
REQ-027 Package rx_mode_pkg SHALL hold the state enum, mode encodings (MODE_1X=0, MODE_3X=1, MODE_5X=2, MODE_OFF=3) and the mode-to-redundancy mapping function.
REQ-028 The synchronizer plus debounce SHALL be the sub-module rx_sw_debounce (width 2, parameter DEBOUNCE_CYC).

Verification
REQ-029 Bench SHALL cover (DEBOUNCE_CYC=4, GAP_CYC=12, DRAIN_CYC=8):
- mode_req 0->1 while idle -> after sync+4 cycles, path_rst_n low 8 cycles, then mode_sel=1, redundancy=3.
- mode_req 1->2 during a 100-cycle frame -> no change until frame end+12 gap cycles, then DRAIN, redundancy=5.
- rx_enable rises in DRAIN cycle 3 -> en_gate 0 through frame end, frame_cnt unchanged.
- mode_req glitch of 2 cycles -> no switch, busy stays 0.
- 3 frames, 2 loss_in pulses, clr_cnt asserted in the same cycle as a 4th frame start -> frame_cnt=0, loss_cnt=0; CNT_W=4 with 20 frames -> frame_cnt=15.
- rst_n low mid-DRAIN -> mode_sel=0, path_rst_n=0 immediately; after release, IDLE with no switch.
